// File: rtl/tmr_pkg.sv
// Shared types for the TMR slice voter: health state encoding and run-counter width.
package tmr_pkg;

    typedef enum logic [1:0] {
        HEALTHY  = 2'd0,
        DEGRADED = 2'd1,
        FAULT    = 2'd2
    } health_t;

    // Wide enough for any legal THRESH (1..255).
    localparam int RUN_W = 8;

endpackage

// File: rtl/tmr_slice_voter_if.sv
// Data-path bundle for the voter: three replica buses in, one voted bus out, valid/ready both sides.
interface tmr_slice_voter_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
);
    logic [LANES*WIDTH-1:0] rep_a;
    logic [LANES*WIDTH-1:0] rep_b;
    logic [LANES*WIDTH-1:0] rep_c;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  rep_a, rep_b, rep_c, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output rep_a, rep_b, rep_c, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/tmr_lane_vote.sv
// Bitwise 2-of-3 majority for one lane, plus a flag when the replicas disagree anywhere.
module tmr_lane_vote #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);
    assign voted    = (a & b) | (a & c) | (b & c);
    assign mismatch = |((a ^ b) | (a ^ c));
endmodule

// File: rtl/tmr_slice_voter.sv
// Triple-modular-redundancy voter with a one-stage skid-free output register and
// sticky error tracking feeding a HEALTHY/DEGRADED/FAULT health FSM.
module tmr_slice_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 2,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tmr_slice_voter_if.slave       bus,
    input  logic                   clr_err,
    (* tamara_error_sink *)
    output logic                   err,
    output logic [LANES-1:0]       err_lane,
    output logic [CNT_W-1:0]       err_count,
    output logic [1:0]             health
);
    localparam logic [RUN_W-1:0] THRESH_L = RUN_W'(THRESH);

    logic [LANES*WIDTH-1:0] voted;
    logic [LANES-1:0]       lane_mm;
    logic                   accept;
    logic                   beat_mm;

    logic [LANES*WIDTH-1:0] out_data_reg;
    logic                   out_valid_reg;
    logic                   err_reg;
    logic [LANES-1:0]       err_lane_reg;
    logic [CNT_W-1:0]       err_count_reg;
    logic [RUN_W-1:0]       run_reg;
    health_t                health_reg;

    logic [RUN_W-1:0]       run_next;
    logic [CNT_W-1:0]       count_next;
    logic [LANES-1:0]       lane_next;
    health_t                health_next;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        tmr_lane_vote #(.WIDTH(WIDTH)) u_vote (
            .a        (bus.rep_a[gi*WIDTH +: WIDTH]),
            .b        (bus.rep_b[gi*WIDTH +: WIDTH]),
            .c        (bus.rep_c[gi*WIDTH +: WIDTH]),
            .voted    (voted[gi*WIDTH +: WIDTH]),
            .mismatch (lane_mm[gi])
        );
    end

    assign bus.in_ready  = !out_valid_reg || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign beat_mm       = |lane_mm;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (bus.in_ready) begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                out_data_reg <= voted;
            end
        end
    end

    // Next-state values for a mismatching beat; a simultaneous clear restarts from zero
    // so the beat still gets recorded.
    always_comb begin
        run_next    = clr_err ? '0 : run_reg;
        run_next    = (run_next == '1) ? run_next : run_next + 1'b1;
        count_next  = clr_err ? '0 : err_count_reg;
        count_next  = (count_next == '1) ? count_next : count_next + 1'b1;
        lane_next   = (clr_err ? '0 : err_lane_reg) | lane_mm;
        health_next = DEGRADED;
        if ((health_reg == FAULT && !clr_err) || run_next >= THRESH_L) begin
            health_next = FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg       <= 1'b0;
            err_lane_reg  <= '0;
            err_count_reg <= '0;
            run_reg       <= '0;
            health_reg    <= HEALTHY;
        end else if (accept && beat_mm) begin
            err_reg       <= 1'b1;
            err_lane_reg  <= lane_next;
            err_count_reg <= count_next;
            run_reg       <= run_next;
            health_reg    <= health_next;
        end else if (clr_err) begin
            err_reg       <= 1'b0;
            err_lane_reg  <= '0;
            err_count_reg <= '0;
            run_reg       <= '0;
            health_reg    <= HEALTHY;
        end else if (accept) begin
            // A clean beat breaks the run but never restores HEALTHY on its own.
            run_reg <= '0;
        end
    end

    assign err       = err_reg;
    assign err_lane  = err_lane_reg;
    assign err_count = err_count_reg;
    assign health    = health_reg;

endmodule

// File: doc/tmr_slice_voter.md
TMR_SLICE_VOTER -- requirements
Module: tmr_slice_voter

Interface
REQ-001 Parameter WIDTH, default 8, bits per lane.
REQ-002 Parameter LANES, default 2, independent lanes (slices) per beat.
REQ-003 Parameter THRESH, default 4, consecutive mismatching beats that trigger FAULT; legal range 1..255.
REQ-004 Parameter CNT_W, default 8, width of the error counter.
REQ-005 Port clk, input, 1, single clock; all state on rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 Ports rep_a, rep_b, rep_c, input, LANES*WIDTH, three replicas of one logical value; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port in_valid, input, 1, replicas valid.
REQ-009 Port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-010 Port out_data, output, LANES*WIDTH, voted result.
REQ-011 Port out_valid, output, 1, out_data valid.
REQ-012 Port out_ready, input, 1, downstream accepts when out_valid && out_ready.
REQ-013 Port err, output, 1, sticky error flag, carrying the tamara_error_sink attribute.
REQ-014 Port err_lane, output, LANES, sticky per-lane mismatch mask.
REQ-015 Port err_count, output, CNT_W, saturating count of mismatching beats.
REQ-016 Port health, output, 2, current health state encoding.
REQ-017 Port clr_err, input, 1, synchronous clear of err, err_lane, err_count and health.

Function
REQ-018 Each out_data bit SHALL be the majority of the corresponding rep_a, rep_b and rep_c bits.
REQ-019 The output stage SHALL be one register stage: out_data and out_valid update one cycle after acceptance.
REQ-020 in_ready SHALL equal !out_valid || out_ready, giving full throughput with no bubble.
REQ-021 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-022 A lane mismatches when any of its bits differ among the three replicas.
REQ-023 A beat mismatches when any lane mismatches; only accepted beats are evaluated.
REQ-024 On an accepted mismatching beat:
- err SHALL be set;
- err_lane SHALL OR in the beat's lane mask;
- err_count SHALL increment by 1, saturating at all-ones.
REQ-025 The health FSM SHALL have states HEALTHY=0, DEGRADED=1 and FAULT=2.
- HEALTHY->DEGRADED on a mismatching beat.
- DEGRADED->FAULT when the run of consecutive mismatching accepted beats reaches THRESH.
- A clean accepted beat SHALL reset the run counter but SHALL NOT leave DEGRADED.
- FAULT and DEGRADED SHALL exit only via clr_err, to HEALTHY.
REQ-026 With THRESH=1, a mismatching beat SHALL move HEALTHY directly to FAULT.
REQ-027 clr_err SHALL clear err, err_lane, err_count, the run counter and health in the following cycle.
REQ-028 If clr_err coincides with a mismatching beat, the beat SHALL win: err=1, err_lane=beat mask, err_count=1, run=1, health=DEGRADED (FAULT if THRESH=1).
REQ-029 Error tracking SHALL NOT stall the data path; data continues to be voted in FAULT.
REQ-030 Stalled input (in_valid && !in_ready) SHALL NOT be evaluated for errors.

Reset
REQ-031 On rst_n low, asynchronously:
- out_valid=0 and out_data=0;
- err=0, err_lane=0, err_count=0;
- run counter=0 and health=HEALTHY.
REQ-032 Reset mid-transfer SHALL discard the held beat; the first accepted beat after release SHALL appear one cycle later.

Structure
REQ-033 The health state enum and its encodings SHALL live in shared package tmr_pkg.
REQ-034 Per-lane voting and mismatch detection SHALL be a sub-module, tmr_lane_vote (WIDTH parameter, combinational), instantiated LANES times.

Verification
REQ-035 The bench SHALL cover the following directed scenarios, with WIDTH=8 and LANES=2.
- Equal replicas 0xA55A on all three, in_valid=1, out_ready=1 -> out_data=0xA55A next cycle, err=0, health=0.
- rep_c=0xA55B, others 0xA55A -> out_data=0xA55A, err=1, err_lane=2'b01, err_count=1, health=1.
- Four consecutive lane-1 mismatching beats (THRESH=4) -> health=2 after the fourth, err_count=4, err_lane=2'b10.
- Pattern mismatch, clean, mismatch, mismatch, mismatch -> health stays 1 and never reaches 2.
- Backpressure: out_ready=0 for 3 cycles with one beat held -> out_data stable, in_ready=0, and a second, mismatching stalled beat causes no err_count change.
- clr_err together with a mismatching beat -> err_count=1, health=1; assert rst_n low mid-stall -> all outputs zero immediately.
